mem_test_master: RTL and testbench
==================================

Name: mem_test_master

Overview:
- Avalon-MM master that drives the 8192x32 single-port on-chip memory slave.
- Fills a programmable word range with a deterministic pattern, reads it back and compares, then reports pass/fail plus first-error details.
- Used for board bring-up and as the built-in self-test of the memory slave.
- Controlled from a small start/status interface owned by top-level glue logic.

Parameters:
- ADDR_W, 13, memory word-address width
- DATA_W, 32, memory data width
- ERR_W, 16, error-counter width (saturating)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a test; ignored while busy
- base_addr  in  ADDR_W  first word address, sampled on start
- length  in  ADDR_W+1  number of words, 0..8192, sampled on start
- seed  in  DATA_W  pattern seed, sampled on start
- invert  in  1  pattern select, sampled on start: 0 = seed+i, 1 = ~(seed+i)
- pause  in  1  stall request; freezes the test
- busy  out  1  test in progress
- done  out  1  sticky; set at completion, cleared by start or reset
- pass  out  1  valid when done; 1 means zero mismatches
- error_count  out  ERR_W  mismatch count, saturates at all-ones
- first_err_addr  out  ADDR_W  address of the first mismatch
- first_err_data  out  DATA_W  read data at the first mismatch
- address  out  ADDR_W  Avalon address
- byteenable  out  4  Avalon byteenable; constant 4'hF
- chipselect  out  1  Avalon chipselect
- write  out  1  Avalon write
- writedata  out  DATA_W  Avalon writedata
- clken  out  1  memory clock enable; equals ~pause
- readdata  in  DATA_W  Avalon readdata; fixed read latency 1 (valid the cycle after the address is presented)

Behaviour:
- Reset: state IDLE; busy, done, pass, error_count, first_err_*, chipselect, write, address, writedata all 0; byteenable 4'hF.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE, on start:
  - latch base_addr, length, seed, invert;
  - clear done, pass, error_count and first_err_*;
  - go to WRITE (or DONE with pass=1 if length==0, in the next cycle);
  - busy=1 from the cycle after start.
- WRITE: one write per enabled cycle.
  - address = base + i (mod 2^ADDR_W); writedata = pattern(i); chipselect=1, write=1.
  - i runs 0..length-1. After the last write go to READ with i=0.
- READ: one read per enabled cycle (chipselect=1, write=0, same address sequence).
  - The expected value and address are pipelined one stage, matching the read latency.
- Compare: happens in the cycle after each read issue.
  - On mismatch, error_count increments (saturating).
  - If it is the first mismatch, capture first_err_addr and first_err_data.
- After the last read is issued go to DRAIN (1 enabled cycle, final compare only, chipselect=0), then DONE.
- DONE: busy=0, done=1, pass=(error_count==0); return to IDLE the next cycle. done and pass stay sticky until the next start or reset.
- pause=1:
  - clken=0;
  - FSM, index, compare pipeline and all Avalon outputs hold;
  - no compare is performed (readdata is frozen by the memory clock enable).
  - Resuming continues with no lost or duplicated access.
- Address wrap: base+i wraps modulo 8192. length=8192 covers every word exactly once.
- Pattern arithmetic is modulo 2^DATA_W.
- start while busy is ignored. start coincident with reset is ignored.
- Reset mid-test aborts immediately to the reset state; memory contents are undefined afterwards.
- Latency: length writes + length reads + 1 drain + 1 done cycle, plus paused cycles.

Decomposition:
- Shared package mem_test_pkg holds:
  - FSM state enum;
  - ADDR_W/DATA_W defaults;
  - pattern function pattern(seed, i, invert).
- One natural sub-module: mem_test_checker. It contains the 1-stage expected-data/address pipeline, compare, saturating error counter and first-error capture, and has the same enable as clken.

Test Plan:
- base=0, length=16, seed=0x1000, invert=0 against a clean memory model -> writes 0x1000..0x100F to 0..15; done after 34 cycles; pass=1, error_count=0.
- Same test, model corrupts word 5 on readback to 0xDEAD0000 -> pass=0, error_count=1, first_err_addr=5, first_err_data=0xDEAD0000.
- base=8190, length=4, invert=1, seed=0 -> addresses 8190, 8191, 0, 1; data 0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFFFD, 0xFFFFFFFC; pass=1.
- length=0 -> no chipselect ever asserted; done=1, pass=1 within 2 cycles of start.
- pause high for 3 cycles mid-WRITE and 3 cycles mid-READ, length=8 -> identical memory image and pass=1; total time extended by exactly 6 cycles.
- reset asserted mid-READ, then a new start with length=2 -> all status outputs 0 after reset; new test completes with correct results; error_count saturation checked with a model returning all-zeros, length=8192, seed=1 -> error_count=8192 (no saturation at ERR_W=16).

Source files
------------

// File: rtl/mem_test_pkg.sv
// Shared types, default widths and the test-pattern generator for the memory self-test master.
package mem_test_pkg;

    localparam int unsigned MEM_ADDR_W = 13;
    localparam int unsigned MEM_DATA_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain,
        StDone
    } state_e;

    // Word i of the fill pattern; arithmetic wraps at the data width.
    function automatic logic [MEM_DATA_W-1:0] pattern(input logic [MEM_DATA_W-1:0] seed,
                                                      input logic [MEM_DATA_W-1:0] idx,
                                                      input logic              invert);
        logic [MEM_DATA_W-1:0] p;
        p = seed + idx;
        return invert ? ~p : p;
    endfunction

endpackage

// File: rtl/mem_test_master_if.sv
// Avalon-MM link between the self-test master and the single-port memory slave.
interface mem_test_master_if
    import mem_test_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
);
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              clken;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, byteenable, chipselect, write, writedata, clken,
        input  readdata
    );

    modport slave (
        input  address, byteenable, chipselect, write, writedata, clken,
        output readdata
    );
endinterface

// File: rtl/mem_test_checker.sv
// Readback checker: one-stage expected-value pipeline matching the memory read latency,
// compare, saturating mismatch counter and first-mismatch capture.
module mem_test_checker
    import mem_test_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W,
    parameter int unsigned ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clear,
    input  logic              issue,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [DATA_W-1:0] readdata,
    output logic [ERR_W-1:0]  error_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
);
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

    logic              vld_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [ERR_W-1:0]  err_q;
    logic [ADDR_W-1:0] fa_q;
    logic [DATA_W-1:0] fd_q;
    logic              mismatch;

    // readdata is frozen while en is low, so comparing then would double count.
    assign mismatch = en && vld_q && (readdata != data_q);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            vld_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= '0;
            fa_q   <= '0;
            fd_q   <= '0;
        end else if (en) begin
            vld_q  <= issue;
            addr_q <= exp_addr;
            data_q <= exp_data;
            if (mismatch) begin
                if (!(&err_q)) err_q <= err_q + ERR_ONE;
                if (err_q == '0) begin
                    fa_q <= addr_q;
                    fd_q <= readdata;
                end
            end
        end
    end

    assign error_count    = err_q;
    assign first_err_addr = fa_q;
    assign first_err_data = fd_q;

endmodule

// File: rtl/mem_test_master.sv
// Memory self-test master: fills a word range with a seeded pattern, reads it back
// through the checker and reports pass/fail with first-error details.
module mem_test_master
    import mem_test_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W,
    parameter int unsigned ERR_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    input  logic [DATA_W-1:0]   seed,
    input  logic                invert,
    input  logic                pause,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    error_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   first_err_data,
    mem_test_master_if.master   avm
);
    localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] seed_q;
    logic              inv_q;
    logic              done_q;
    logic              en, accept, last, issue;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;

    assign en       = ~pause;
    assign accept   = start && (state_q == StIdle);
    assign last     = (idx_q == len_q - IDX_ONE);
    assign issue    = (state_q == StRead);
    assign cur_addr = base_q + idx_q[ADDR_W-1:0];
    assign cur_data = DATA_W'(pattern(MEM_DATA_W'(seed_q), MEM_DATA_W'(idx_q), inv_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            len_q   <= '0;
            base_q  <= '0;
            seed_q  <= '0;
            inv_q   <= 1'b0;
            done_q  <= 1'b0;
        end else if (accept) begin
            // An empty range completes immediately with nothing to check.
            state_q <= (length == '0) ? StDone : StWrite;
            idx_q   <= '0;
            len_q   <= length;
            base_q  <= base_addr;
            seed_q  <= seed;
            inv_q   <= invert;
            done_q  <= (length == '0);
        end else if (en) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == StDrain) done_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle:  state_d = StIdle;
            StWrite: begin
                idx_d = idx_q + IDX_ONE;
                if (last) begin
                    state_d = StRead;
                    idx_d   = '0;
                end
            end
            StRead: begin
                idx_d = idx_q + IDX_ONE;
                if (last) state_d = StDrain;
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        avm.address    = '0;
        avm.writedata  = '0;
        avm.chipselect = 1'b0;
        avm.write      = 1'b0;
        if (state_q == StWrite || state_q == StRead) begin
            avm.address    = cur_addr;
            avm.chipselect = 1'b1;
        end
        if (state_q == StWrite) begin
            avm.write     = 1'b1;
            avm.writedata = cur_data;
        end
    end

    assign avm.byteenable = 4'hF;
    assign avm.clken      = en;

    mem_test_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ERR_W  (ERR_W)
    ) u_checker (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .clear          (accept),
        .issue          (issue),
        .exp_addr       (cur_addr),
        .exp_data       (cur_data),
        .readdata       (avm.readdata),
        .error_count    (error_count),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data)
    );

    assign busy = (state_q == StWrite) || (state_q == StRead) || (state_q == StDrain);
    assign done = done_q;
    assign pass = done_q && (error_count == '0);

endmodule

// File: tb/tb_mem_test_master.sv
// Self-checking bench for mem_test_master against a latency-1 memory model with
// optional readback corruption.
module tb_mem_test_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [12:0] base_addr = '0;
    logic [13:0] length = '0;
    logic [31:0] seed = '0;
    logic        invert = 1'b0;
    logic        pause = 1'b0;
    logic        busy, done, pass;
    logic [15:0] error_count;
    logic [12:0] first_err_addr;
    logic [31:0] first_err_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:8191];
    logic        zero_mode = 1'b0;
    logic        corrupt_on = 1'b0;
    logic [12:0] corrupt_addr = '0;
    int          cs_cnt = 0;

    mem_test_master_if #(.ADDR_W(13), .DATA_W(32)) bus ();

    mem_test_master #(.ADDR_W(13), .DATA_W(32), .ERR_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .seed           (seed),
        .invert         (invert),
        .pause          (pause),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .error_count    (error_count),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data),
        .avm            (bus)
    );

    always #5 clk = ~clk;

    // Single-port memory, read latency 1, everything frozen when clken is low.
    always @(posedge clk) begin
        if (bus.clken) begin
            if (bus.chipselect && bus.write) mem[bus.address] <= bus.writedata;
            if (bus.chipselect) begin
                if (zero_mode) bus.readdata <= 32'h0;
                else if (corrupt_on && bus.address == corrupt_addr) bus.readdata <= 32'hDEAD0000;
                else bus.readdata <= mem[bus.address];
            end
            if (bus.chipselect) cs_cnt <= cs_cnt + 1;
        end
    end

    typedef struct {
        logic [12:0] base;
        logic [13:0] len;
        logic [31:0] seed;
        logic        inv;
        logic        zero;
        logic        corrupt;
        logic [12:0] caddr;
        int          pw;     // first paused cycle in WRITE (0 = none), 3 cycles long
        int          pr;     // first paused cycle in READ (0 = none), 3 cycles long
        int          rs;     // cycle of a stray start pulse while busy (0 = none)
        logic [15:0] e_err;
        logic [12:0] e_fa;
        logic [31:0] e_fd;
        int          e_lat;  // edges from the start-sampling edge until done is seen
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] s, input int i, input logic inv);
        logic [31:0] p;
        p = s + 32'(i);
        return inv ? ~p : p;
    endfunction

    task automatic chk_cleared(input string pfx);
        chk({pfx, " busy"}, 32'(busy), 32'd0);
        chk({pfx, " done"}, 32'(done), 32'd0);
        chk({pfx, " pass"}, 32'(pass), 32'd0);
        chk({pfx, " err"}, 32'(error_count), 32'd0);
        chk({pfx, " faddr"}, 32'(first_err_addr), 32'd0);
        chk({pfx, " fdata"}, first_err_data, 32'd0);
        chk({pfx, " avm"}, {13'd0, bus.address, 3'd0, bus.chipselect, bus.write, bus.byteenable},
            32'h0000_000F);
        chk({pfx, " wdata"}, bus.writedata, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int lat;
        int ck_bad;
        int cs0;
        int bad;
        logic [12:0] a;
        zero_mode    = v.zero;
        corrupt_on   = v.corrupt;
        corrupt_addr = v.caddr;
        @(negedge clk);
        base_addr = v.base;
        length    = v.len;
        seed      = v.seed;
        invert    = v.inv;
        start     = 1'b1;
        cs0       = cs_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk($sformatf("v%0d busy", k), 32'(busy), 32'(v.len != 0));
        lat    = 0;
        ck_bad = 0;
        while (done !== 1'b1 && lat < 20000) begin
            if (bus.clken !== !pause) ck_bad++;
            pause = (v.pw != 0 && lat >= v.pw && lat < v.pw + 3) ||
                    (v.pr != 0 && lat >= v.pr && lat < v.pr + 3);
            start = (v.rs != 0 && lat == v.rs);
            if (start) length = '0;
            @(posedge clk);
            #1;
            lat++;
        end
        pause = 1'b0;
        start = 1'b0;
        chk($sformatf("v%0d latency", k), 32'(lat), 32'(v.e_lat));
        chk($sformatf("v%0d err", k), 32'(error_count), 32'(v.e_err));
        chk($sformatf("v%0d pass", k), 32'(pass), 32'(v.e_err == 0));
        chk($sformatf("v%0d faddr", k), 32'(first_err_addr), 32'(v.e_fa));
        chk($sformatf("v%0d fdata", k), first_err_data, v.e_fd);
        chk($sformatf("v%0d accesses", k), 32'(cs_cnt - cs0), 32'(2 * int'(v.len)));
        chk($sformatf("v%0d clken", k), 32'(ck_bad), 32'd0);
        bad = 0;
        for (int i = 0; i < int'(v.len); i++) begin
            a = v.base + 13'(i);
            if (mem[a] !== exp_word(v.seed, i, v.inv)) bad++;
        end
        chk($sformatf("v%0d image", k), 32'(bad), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("v%0d sticky", k), {29'd0, done, pass, busy}, {29'd0, 1'b1, v.e_err == 0, 1'b0});
    endtask

    initial begin
        vec_t v2;
        //          base      len         seed          inv   zero  corr  caddr    pw pr  rs
        //          e_err      e_fa      e_fd           e_lat
        vecs[0] = '{13'd0,    14'd16,   32'h0000_1000, 1'b0, 1'b0, 1'b0, 13'd0,   0, 0,  0,
                    16'd0,    13'd0,    32'h0,          33};
        vecs[1] = '{13'd0,    14'd16,   32'h0000_1000, 1'b0, 1'b0, 1'b1, 13'd5,   0, 0,  0,
                    16'd1,    13'd5,    32'hDEAD_0000,  33};
        vecs[2] = '{13'd77,   14'd0,    32'h1234_5678, 1'b0, 1'b0, 1'b0, 13'd0,   0, 0,  0,
                    16'd0,    13'd0,    32'h0,          0};
        vecs[3] = '{13'd100,  14'd8,    32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 13'd103, 0, 0,  0,
                    16'd1,    13'd103,  32'hDEAD_0000,  17};
        vecs[4] = '{13'd300,  14'd8,    32'h0000_0055, 1'b0, 1'b0, 1'b0, 13'd0,   3, 13, 0,
                    16'd0,    13'd0,    32'h0,          23};
        vecs[5] = '{13'd200,  14'd8,    32'hABCD_0000, 1'b1, 1'b0, 1'b0, 13'd0,   0, 0,  6,
                    16'd0,    13'd0,    32'h0,          17};
        vecs[6] = '{13'd0,    14'd8192, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 13'd0,   0, 0,  0,
                    16'd8192, 13'd0,    32'h0,          16385};
        vecs[7] = '{13'd8190, 14'd4,    32'h0000_0000, 1'b1, 1'b0, 1'b0, 13'd0,   0, 0,  0,
                    16'd0,    13'd0,    32'h0,          9};

        repeat (3) @(posedge clk);
        #1;
        chk_cleared("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

        chk("wrap 8190", mem[13'd8190], 32'hFFFF_FFFF);
        chk("wrap 8191", mem[13'd8191], 32'hFFFF_FFFE);
        chk("wrap 0", mem[13'd0], 32'hFFFF_FFFD);
        chk("wrap 1", mem[13'd1], 32'hFFFF_FFFC);

        // Abort mid-READ once an error has been recorded, with a start on the reset edge.
        zero_mode    = 1'b0;
        corrupt_on   = 1'b1;
        corrupt_addr = 13'd5;
        @(negedge clk);
        base_addr = 13'd0;
        length    = 14'd16;
        seed      = 32'h0000_1000;
        invert    = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("abort pre err", 32'(error_count), 32'd1);
        chk("abort pre busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk_cleared("abort");
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("start with reset ignored", 32'(busy), 32'd0);

        v2 = '{13'd50, 14'd2, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 13'd0, 0, 0, 0,
               16'd0, 13'd0, 32'h0, 5};
        run_vec(v2, 8);
        chk("rerun word 50", mem[13'd50], 32'h0000_0007);
        chk("rerun word 51", mem[13'd51], 32'h0000_0008);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
